// File: rtl/clk_div_monitor.sv
// ---------------------------------------------------------------------------
// clk_div_monitor
//   Health checker for a divided clock. div_clk is sampled as plain data in the
//   clk domain. The monitor measures the spacing between its rising edges in clk
//   cycles. It declares lock after LOCK_CNT consecutive in-tolerance periods.
//   It flags bad periods and stalls, and counts them in a saturating counter.
//
// Ports
//   clk         in   1      source clock, all logic on posedge
//   rst         in   1      asynchronous active-low reset
//   en          in   1      monitor enable; dropping it returns to IDLE
//   div_clk     in   1      divided clock under test (asynchronous data)
//   clr_err     in   1      synchronous clear of err_cnt (beats an increment)
//   period      out  CNT_W  last measured period
//   period_vld  out  1      one-cycle pulse when period is updated
//   locked      out  1      divided clock is in tolerance
//   fault       out  1      period error or stall since the last lock
//   stall       out  1      no rising edge within TIMEOUT cycles
//   err_cnt     out  ERR_W  saturating count of bad periods and stall entries
// ---------------------------------------------------------------------------
module clk_div_monitor #(
  parameter int EXP_PERIOD = 3,
  parameter int TOL        = 0,
  parameter int CNT_W      = 8,
  parameter int LOCK_CNT   = 4,
  parameter int TIMEOUT    = 16,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             div_clk,
  input  logic             clr_err,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic             locked,
  output logic             fault,
  output logic             stall,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int GW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);

  localparam logic [CNT_W-1:0] EXP_C     = CNT_W'(EXP_PERIOD);
  localparam logic [CNT_W-1:0] TOL_C     = CNT_W'(TOL);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [GW-1:0]    LAST_GOOD = GW'(LOCK_CNT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACQ    = 3'd1,
    TRACK  = 3'd2,
    LOCKED = 3'd3,
    FAULT  = 3'd4
  } state_t;

  state_t           state;
  logic             s1, s2, s3;
  logic [CNT_W-1:0] cnt;
  logic [GW-1:0]    good_cnt;

  logic             rise;
  logic             timeout;
  logic             good;
  logic [CNT_W-1:0] diff;
  logic             measuring;
  logic             err_inc;

  // Edge detect on the synchronised copy. s1/s2 form the synchroniser, and s3
  // holds the previous sample for the edge compare.
  assign rise    = s2 & ~s3;
  assign timeout = (cnt >= TIMEOUT_C) & ~rise;

  // Subtract the smaller operand from the larger so the deviation never wraps.
  assign diff      = (cnt >= EXP_C) ? (cnt - EXP_C) : (EXP_C - cnt);
  assign good      = (diff <= TOL_C);
  assign measuring = (state == TRACK) || (state == LOCKED) || (state == FAULT);

  // A stall is charged once when it starts. The stall flag then masks the
  // timeout until the next rising edge clears it.
  assign err_inc = en && (state != IDLE) &&
                   ((rise && measuring && !good) || (timeout && !stall));

  // NOTE: every flop in this module is assigned with <=, so all of them sample
  // the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      cnt        <= '0;
      good_cnt   <= '0;
      period     <= '0;
      period_vld <= 1'b0;
      locked     <= 1'b0;
      fault      <= 1'b0;
      stall      <= 1'b0;
    end else begin
      s1         <= div_clk;
      s2         <= s1;
      s3         <= s2;
      period_vld <= 1'b0;

      if (!en) begin
        // period is kept so status logic can still read the last measurement.
        state    <= IDLE;
        cnt      <= '0;
        good_cnt <= '0;
        locked   <= 1'b0;
        fault    <= 1'b0;
        stall    <= 1'b0;
      end else begin
        if (rise)            cnt <= CNT_W'(1);
        else if (cnt != '1)  cnt <= cnt + 1'b1;

        if (rise && measuring) begin
          period     <= cnt;
          period_vld <= 1'b1;
        end

        if (rise) stall <= 1'b0;
        else if (timeout && !stall && state != IDLE) stall <= 1'b1;

        unique case (state)
          IDLE: state <= ACQ;

          ACQ: begin
            if (rise) begin
              state    <= TRACK;
              good_cnt <= '0;
            end else if (timeout) begin
              state    <= FAULT;
              fault    <= 1'b1;
              good_cnt <= '0;
            end
          end

          TRACK, FAULT: begin
            if (rise) begin
              if (!good) begin
                good_cnt <= '0;
              end else if (good_cnt == LAST_GOOD) begin
                state    <= LOCKED;
                locked   <= 1'b1;
                fault    <= 1'b0;
                good_cnt <= '0;
              end else begin
                good_cnt <= good_cnt + 1'b1;
              end
            end else if (timeout && state == TRACK) begin
              state    <= FAULT;
              fault    <= 1'b1;
              good_cnt <= '0;
            end
          end

          LOCKED: begin
            if ((rise && !good) || timeout) begin
              state    <= FAULT;
              locked   <= 1'b0;
              fault    <= 1'b1;
              good_cnt <= '0;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

  // Error counter. It is not cleared by en, and clr_err takes priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             err_cnt <= '0;
    else if (clr_err)                     err_cnt <= '0;
    else if (err_inc && err_cnt != '1)    err_cnt <= err_cnt + 1'b1;
  end

endmodule
